// File: rtl/piso_stream.sv
// piso_stream: parallel-in / serial-out streaming converter.
// A word is accepted over a valid/ready handshake and emitted as BEATS lanes
// of LANE_W bits, LSB lane first or MSB lane first as chosen per word.
// Storage is one shifting word plus a one-entry hold buffer, so a second word
// can be queued while the first is shifting and words follow with no gap.
// Words are lane-reordered on entry so the shifter always emits the low lane;
// that normalised word therefore carries the per-word order selection.
// DATA_W must be >= 2 and LANE_W must divide DATA_W exactly.
module piso_stream #(
    parameter int DATA_W = 8,
    parameter int LANE_W = 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              flush,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              msb_first,
    output logic [LANE_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_first,
    output logic              out_last,
    output logic              done,
    output logic              busy
);

    localparam int BEATS = DATA_W / LANE_W;
    localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BEATS - 1);

    // Shift stage
    logic [DATA_W-1:0] sh_word_q, sh_word_d;
    logic              sh_valid_q, sh_valid_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    // Hold buffer
    logic [DATA_W-1:0] hold_word_q, hold_word_d;
    logic              hold_full_q, hold_full_d;
    // Registered outputs
    logic [LANE_W-1:0] out_data_q, out_data_d;
    logic              out_first_q, out_first_d;
    logic              out_last_q, out_last_d;
    logic              done_q, done_d;
    logic              busy_q, busy_d;

    logic [DATA_W-1:0] in_rev;
    logic [DATA_W-1:0] in_norm;
    logic              fire_in;
    logic              fire_out;
    logic              last_done;

    // Lane-reversed copy of the input word: lane gi takes lane BEATS-1-gi.
    // Bit order inside each lane is preserved.
    generate
        for (genvar gi = 0; gi < BEATS; gi++) begin : g_rev
            assign in_rev[gi*LANE_W +: LANE_W] = in_data[(BEATS-1-gi)*LANE_W +: LANE_W];
        end
    endgenerate

    assign in_norm   = msb_first ? in_rev : in_data;

    // A held word blocks new input; flush and reset also refuse transfers.
    assign in_ready  = reset_n & ~hold_full_q & ~flush;
    assign fire_in   = in_valid & in_ready;
    assign fire_out  = sh_valid_q & out_ready;
    assign last_done = fire_out & (cnt_q == LAST_CNT);

    // Next-state logic for the shift stage, hold buffer and registered outputs.
    always_comb begin
        sh_word_d   = sh_word_q;
        sh_valid_d  = sh_valid_q;
        cnt_d       = cnt_q;
        hold_word_d = hold_word_q;
        hold_full_d = hold_full_q;
        done_d      = 1'b0;

        if (flush) begin
            sh_word_d   = '0;
            sh_valid_d  = 1'b0;
            cnt_d       = '0;
            hold_word_d = '0;
            hold_full_d = 1'b0;
        end else begin
            done_d = last_done;
            if (fire_out) begin
                if (last_done) begin
                    cnt_d = '0;
                    if (hold_full_q) begin
                        // Held word takes over on the same edge: no idle beat.
                        sh_word_d   = hold_word_q;
                        hold_full_d = 1'b0;
                    end else begin
                        sh_valid_d = 1'b0;
                    end
                end else begin
                    cnt_d     = cnt_q + 1'b1;
                    sh_word_d = sh_word_q >> LANE_W;
                end
            end
            // fire_in implies the hold buffer is empty, so it cannot collide
            // with the hold-to-shift move above.
            if (fire_in) begin
                if (!sh_valid_q || last_done) begin
                    sh_word_d  = in_norm;
                    sh_valid_d = 1'b1;
                    cnt_d      = '0;
                end else begin
                    hold_word_d = in_norm;
                    hold_full_d = 1'b1;
                end
            end
        end

        out_data_d  = sh_valid_d ? sh_word_d[LANE_W-1:0] : '0;
        out_first_d = sh_valid_d & (cnt_d == '0);
        out_last_d  = sh_valid_d & (cnt_d == LAST_CNT);
        busy_d      = sh_valid_d | hold_full_d;
    end

    // Datapath state registers with asynchronous clear.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sh_word_q   <= '0;
            sh_valid_q  <= 1'b0;
            cnt_q       <= '0;
            hold_word_q <= '0;
            hold_full_q <= 1'b0;
        end else begin
            sh_word_q   <= sh_word_d;
            sh_valid_q  <= sh_valid_d;
            cnt_q       <= cnt_d;
            hold_word_q <= hold_word_d;
            hold_full_q <= hold_full_d;
        end
    end

    // Output registers with asynchronous clear.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_data_q  <= '0;
            out_first_q <= 1'b0;
            out_last_q  <= 1'b0;
            done_q      <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            out_data_q  <= out_data_d;
            out_first_q <= out_first_d;
            out_last_q  <= out_last_d;
            done_q      <= done_d;
            busy_q      <= busy_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_valid = sh_valid_q;
    assign out_first = out_first_q;
    assign out_last  = out_last_q;
    assign done      = done_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_piso_stream.sv
// Testbench for piso_stream: two instances (8/1 and 16/4) checked by a
// per-instance scoreboard of expected beats built from each accepted word.
module tb_piso_stream;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Instance A: DATA_W=8, LANE_W=1
    logic        rst_a = 1'b0, flush_a = 1'b0, in_valid_a = 1'b0, msb_a = 1'b0, out_ready_a = 1'b1;
    logic [7:0]  in_data_a = '0;
    logic        in_ready_a, out_valid_a, out_first_a, out_last_a, done_a, busy_a;
    logic [0:0]  out_data_a;

    // Instance B: DATA_W=16, LANE_W=4
    logic        rst_b = 1'b0, flush_b = 1'b0, in_valid_b = 1'b0, msb_b = 1'b0, out_ready_b = 1'b1;
    logic [15:0] in_data_b = '0;
    logic        in_ready_b, out_valid_b, out_first_b, out_last_b, done_b, busy_b;
    logic [3:0]  out_data_b;

    piso_stream #(.DATA_W(8), .LANE_W(1)) u_a (
        .clk(clk), .reset_n(rst_a), .flush(flush_a),
        .in_data(in_data_a), .in_valid(in_valid_a), .in_ready(in_ready_a), .msb_first(msb_a),
        .out_data(out_data_a), .out_valid(out_valid_a), .out_ready(out_ready_a),
        .out_first(out_first_a), .out_last(out_last_a), .done(done_a), .busy(busy_a)
    );

    piso_stream #(.DATA_W(16), .LANE_W(4)) u_b (
        .clk(clk), .reset_n(rst_b), .flush(flush_b),
        .in_data(in_data_b), .in_valid(in_valid_b), .in_ready(in_ready_b), .msb_first(msb_b),
        .out_data(out_data_b), .out_valid(out_valid_b), .out_ready(out_ready_b),
        .out_first(out_first_b), .out_last(out_last_b), .done(done_b), .busy(busy_b)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Scoreboard entry: lane value | first<<8 | last<<9
    int q [2][$];
    int exp_done [2];

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    endtask

    // One cycle of scoreboard bookkeeping, sampled at the falling edge.
    task automatic mon(input int id, input int beats, input int dw, input int lw,
                       input logic rst, input logic flsh, input logic iv, input logic ir,
                       input logic ov, input logic ordy, input int od, input logic of,
                       input logic ol, input logic dn, input logic bz,
                       input int iw, input logic msb);
        int e;
        int mask;
        int lane;
        if (!rst) begin
            check("rst_out_valid", ov, 0);
            check("rst_out_data", od, 0);
            check("rst_out_first", of, 0);
            check("rst_out_last", ol, 0);
            check("rst_done", dn, 0);
            check("rst_busy", bz, 0);
            check("rst_in_ready", ir, 0);
            q[id].delete();
            exp_done[id] = 0;
            return;
        end
        check("in_ready", ir, int'(!flsh && q[id].size() <= beats));
        check("busy", bz, int'(q[id].size() != 0));
        check("out_valid", ov, int'(q[id].size() != 0));
        check("done", dn, exp_done[id]);
        if (ov && q[id].size() != 0) begin
            e = q[id][0];
            check("beat_data", od, e & 'hFF);
            check("beat_first", of, (e >> 8) & 1);
            check("beat_last", ol, (e >> 9) & 1);
        end else if (!ov) begin
            check("idle_data", od, 0);
        end
        exp_done[id] = 0;
        if (flsh) begin
            q[id].delete();
            return;
        end
        if (ov && ordy && q[id].size() != 0) begin
            e = q[id].pop_front();
            if (((e >> 9) & 1) == 1) exp_done[id] = 1;
        end
        if (iv && ir) begin
            mask = (1 << lw) - 1;
            for (int k = 0; k < beats; k++) begin
                if (msb) lane = (iw >> (dw - (k + 1) * lw)) & mask;
                else     lane = (iw >> (k * lw)) & mask;
                q[id].push_back(lane | (int'(k == 0) << 8) | (int'(k == beats - 1) << 9));
            end
            $display("[%0t] inst %0d accept word %0h msb_first=%0d", $time, id, iw, msb);
        end
    endtask

    always @(negedge clk)
        mon(0, 8, 8, 1, rst_a, flush_a, in_valid_a, in_ready_a, out_valid_a, out_ready_a,
            int'(out_data_a), out_first_a, out_last_a, done_a, busy_a, int'(in_data_a), msb_a);

    always @(negedge clk)
        mon(1, 4, 16, 4, rst_b, flush_b, in_valid_b, in_ready_b, out_valid_b, out_ready_b,
            int'(out_data_b), out_first_b, out_last_b, done_b, busy_b, int'(in_data_b), msb_b);

    task automatic send_a(input logic [7:0] w, input logic m);
        int n = 0;
        in_data_a = w; msb_a = m; in_valid_a = 1'b1;
        @(negedge clk);
        while (!in_ready_a && n < 100) begin n++; @(negedge clk); end
        if (n >= 100) check("send_a_timeout", 0, 1);
        @(posedge clk); #1;
        in_valid_a = 1'b0;
    endtask

    task automatic send_b(input logic [15:0] w, input logic m);
        int n = 0;
        in_data_b = w; msb_b = m; in_valid_b = 1'b1;
        @(negedge clk);
        while (!in_ready_b && n < 100) begin n++; @(negedge clk); end
        if (n >= 100) check("send_b_timeout", 0, 1);
        @(posedge clk); #1;
        in_valid_b = 1'b0;
    endtask

    task automatic wait_idle(input int id);
        int n = 0;
        @(negedge clk);
        while (((id == 0) ? busy_a : busy_b) && n < 200) begin n++; @(negedge clk); end
        if (n >= 200) check("idle_timeout", 0, 1);
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        rst_a = 1'b1; rst_b = 1'b1;
        @(posedge clk); #1;

        // 8'hB4 LSB first then MSB first
        send_a(8'hB4, 1'b0);
        wait_idle(0);
        send_a(8'hB4, 1'b1);
        wait_idle(0);

        // Back-to-back 16-bit words, lanes of 4
        send_b(16'h1234, 1'b0);
        send_b(16'hABCD, 1'b0);
        send_b(16'h5A3C, 1'b1);
        wait_idle(1);

        // Consumer stall for 3 cycles mid-word
        send_a(8'h5C, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        out_ready_a = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        out_ready_a = 1'b1;
        wait_idle(0);

        // Asynchronous reset during beat 3 with a word held
        send_a(8'hA5, 1'b0);
        send_a(8'h0F, 1'b1);
        repeat (2) @(posedge clk);
        #1;
        rst_a = 1'b0;
        @(posedge clk); #1;
        rst_a = 1'b1;
        @(posedge clk); #1;
        send_a(8'h3C, 1'b1);
        wait_idle(0);

        // Flush during beat 3 with a word held
        send_b(16'h1234, 1'b0);
        send_b(16'hABCD, 1'b1);
        repeat (2) @(posedge clk);
        #1;
        flush_b = 1'b1;
        @(posedge clk); #1;
        flush_b = 1'b0;
        send_b(16'hC3E1, 1'b1);
        wait_idle(1);

        // Random traffic with consumer backpressure and occasional flush
        for (int i = 0; i < 400; i++) begin
            in_valid_b  = ($urandom % 3) != 0;
            in_data_b   = 16'($urandom);
            msb_b       = 1'($urandom);
            out_ready_b = ($urandom % 4) != 0;
            flush_b     = ($urandom % 60) == 0;
            @(posedge clk); #1;
        end
        in_valid_b = 1'b0; out_ready_b = 1'b1; flush_b = 1'b0;
        wait_idle(1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
